multi_cycle_ctrl: RTL
=====================

// Module: multi_cycle_ctrl
// PURPOSE
//  Moore FSM that sequences the shared multi-cycle MIPS datapath: one ALU, one memory port, IR, A/B/ALUOut/MDR.
//  Decodes OPcode/Fun from IR and drives per-state datapath enables and muxes.
//  Resolves branch conditions, and optionally stalls on MIO_ready.
//  Sits between IR/zero flag and the datapath.
// PARAMETERS
//  none (encodings below are fixed)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  OPcode       in   6  IR[31:26]
//  Fun          in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  MIO_ready    in   1  memory/IO transfer complete
//  PCWrite      out  1  PC load; includes the resolved branch condition
//  IorD         out  1  mem addr: 0=PC, 1=ALUOut
//  MemRead      out  1  memory read strobe
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  IR load
//  RegDst       out  2  00=rt, 01=rd, 10=$31
//  DatatoReg    out  2  00=ALUOut, 01=MDR, 10={imm,16'b0}, 11=PC
//  RegWrite     out  1  register file write
//  ALUSrc_A     out  2  00=PC, 01=A, 10=shamt
//  ALUSrc_B     out  2  00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
//  ALU_Control  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt
//  PCSource     out  2  00=ALU, 01=ALUOut, 10=jump target, 11=A (jr)
//  CPU_MIO      out  1  memory access in progress (MemRead|MemWrite)
//  state        out  4  current FSM state, for debug
//  illegal      out  1  one-cycle pulse in ID on an unsupported opcode/funct
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IF. All outputs 0 while reset is asserted.
//    A reset mid-instruction aborts it; no partial RegWrite or MemWrite is issued.
//  - Outputs are combinational from state and the current OPcode/Fun only. zero affects PCWrite in BR only.
//  - States:
//    IF=0    MemRead, IRWrite, PCWrite, IorD=0, A=PC, B=4, add, PCSource=00
//    ID=1    A=PC, B=imm<<2, add (branch target into ALUOut)
//    MA=2    A=A, B=sext, add
//    MRD=3   MemRead, IorD=1
//    MWB=4   RegWrite, RegDst=rt, DatatoReg=MDR
//    MWR=5   MemWrite, IorD=1
//    EXR=6   A=A (shamt for srl), B=B, funct-decoded ALU op
//    RWB=7   RegWrite, RegDst=rd, DatatoReg=ALUOut
//    BR=8    A=A, B=B, sub, PCSource=01, PCWrite=zero (beq) / ~zero (bne)
//    JMP=9   PCWrite, PCSource=10
//    EXI=10  A=A, B=sext, op: addi add, andi and, ori or, xori xor, slti slt
//    IWB=11  RegWrite, RegDst=rt, DatatoReg=ALUOut
//    JAL=12  RegWrite, RegDst=$31, DatatoReg=PC (already PC+4), PCWrite, PCSource=10
//    JR=13   PCWrite, PCSource=11
//    LUI=14  RegWrite, RegDst=rt, DatatoReg=10
//  - Transitions: IF->ID. ID->by opcode:
//    lw/sw->MA, R->EXR (funct 001000 ->JR), beq/bne->BR, j->JMP, jal->JAL,
//    addi/andi/ori/xori/slti->EXI, lui->LUI.
//    MA->MRD (lw) or MWR (sw). MRD->MWB. EXR->RWB. EXI->IWB.
//    MWB/MWR/RWB/IWB/BR/JMP/JAL/JR/LUI->IF.
//  - Opcodes: lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, lui 001111,
//    ori 001101, andi 001100, xori 001110, slti 001010, addi 001000.
//    R functs: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111,
//    slt 101010, srl 000010, jr 001000.
//  - Unsupported opcode/funct: illegal=1 in ID, then ID->IF; executes as a NOP (PC already advanced).
//  - Latency in cycles, no waits: lw 5; sw/R/imm 4; beq/bne/j/jal/jr/lui 3.
//  - State code 15 is unreachable; if entered, next state is IF with all outputs 0.
// CONFIGURATION
//  MC_MIO_WAIT_EN defined:
//    IF, MRD and MWR hold until MIO_ready=1.
//    Strobes stay asserted while waiting; IRWrite and PCWrite assert only in the cycle with MIO_ready=1.
//  MC_MIO_WAIT_EN undefined: MIO_ready is ignored; every state lasts exactly one cycle.
// TESTING
//  1. rst_n=0 mid-MRD, then release -> outputs 0 during reset; state=0 on the first cycle after release; no RegWrite issued.
//  2. add $3,$1,$2 (000000..100000) -> states 0,1,6,7,0; ALU_Control=010 in EXR; RegWrite with RegDst=01 in RWB.
//  3. lw (100011) -> states 0,1,2,3,4; IorD=1 in MRD; RegWrite with DatatoReg=01 in MWB.
//     sw (101011) -> MemWrite exactly one cycle in state 5.
//  4. beq with zero=1 -> PCWrite=1 and PCSource=01 in BR; zero=0 -> PCWrite=0.
//     bne: the same two cases with the results inverted.
//  5. jal (000011) -> state 12 with RegDst=10, DatatoReg=11, PCWrite=1, PCSource=10; jr -> state 13 with PCSource=11.
//  6. MC_MIO_WAIT_EN, MIO_ready=0 for 3 cycles in IF -> 4 IF cycles; IRWrite and PCWrite only in the last.
//     Opcode 111111 -> illegal pulse, then IF.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//   Moore control FSM for a shared multi-cycle MIPS datapath with one ALU, one
//   memory port and IR/A/B/ALUOut/MDR registers. It decodes OPcode/Fun, drives
//   per-state datapath enables and mux selects, and resolves beq/bne from the
//   ALU zero flag.
//
//   Optional build macro: MC_MIO_WAIT_EN
//     defined   : IF, MRD and MWR hold until MIO_ready=1. Strobes stay up while
//                 waiting; IRWrite/PCWrite in IF assert only with MIO_ready=1.
//     undefined : MIO_ready is ignored and every state lasts one cycle.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   OPcode, Fun         IR[31:26], IR[5:0]
//   zero                ALU zero flag (used in BR only)
//   MIO_ready           memory/IO transfer complete
//   PCWrite .. PCSource datapath enables and mux selects
//   CPU_MIO             MemRead | MemWrite
//   state               current FSM state (debug)
//   illegal             one-cycle pulse in ID on an unsupported opcode/funct
//
// Handshake: MIO_ready is sampled only in IF/MRD/MWR; a memory state completes
// in the cycle where its strobe and MIO_ready are both high.
// -----------------------------------------------------------------------------
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] DatatoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [2:0] ALU_Control,
  output logic [1:0] PCSource,
  output logic       CPU_MIO,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
    S_MWB = 4'd4,  S_MWR = 4'd5,  S_EXR = 4'd6,  S_RWB = 4'd7,
    S_BR  = 4'd8,  S_JMP = 4'd9,  S_EXI = 4'd10, S_IWB = 4'd11,
    S_JAL = 4'd12, S_JR  = 4'd13, S_LUI = 4'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011, OP_LUI  = 6'b001111, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_XORI = 6'b001110, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] FN_SRL  = 6'b000010, FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t     r_state, w_next;
  logic       w_mio_ok;
  logic [2:0] w_r_alu, w_i_alu;
  logic       w_r_ok;
  state_t     w_id_next;
  logic       w_id_ok;

  // Combinational outputs before reset gating.
  logic       w_pcwrite, w_iord, w_memread, w_memwrite, w_irwrite, w_regwrite, w_illegal;
  logic [1:0] w_regdst, w_datatoreg, w_alusrc_a, w_alusrc_b, w_pcsource;
  logic [2:0] w_alu;

`ifdef MC_MIO_WAIT_EN
  assign w_mio_ok = MIO_ready;
`else
  // Transfers always complete in one cycle; MIO_ready has no effect.
  assign w_mio_ok = MIO_ready | 1'b1;
`endif

  // R-type funct decode (jr is routed separately in ID).
  always_comb begin
    w_r_alu = ALU_ADD;
    w_r_ok  = 1'b1;
    case (Fun)
      6'b100000: w_r_alu = ALU_ADD;
      6'b100010: w_r_alu = ALU_SUB;
      6'b100100: w_r_alu = ALU_AND;
      6'b100101: w_r_alu = ALU_OR;
      6'b100110: w_r_alu = ALU_XOR;
      6'b100111: w_r_alu = ALU_NOR;
      6'b101010: w_r_alu = ALU_SLT;
      FN_SRL:    w_r_alu = ALU_SRL;
      FN_JR:     w_r_alu = ALU_ADD;
      default:   w_r_ok  = 1'b0;
    endcase
  end

  // I-type ALU op decode for EXI.
  always_comb begin
    w_i_alu = ALU_ADD;
    case (OPcode)
      OP_ANDI: w_i_alu = ALU_AND;
      OP_ORI:  w_i_alu = ALU_OR;
      OP_XORI: w_i_alu = ALU_XOR;
      OP_SLTI: w_i_alu = ALU_SLT;
      default: w_i_alu = ALU_ADD;
    endcase
  end

  // Dispatch from ID; unsupported encodings fall back to IF as a NOP.
  always_comb begin
    w_id_next = S_IF;
    w_id_ok   = 1'b1;
    case (OPcode)
      OP_LW, OP_SW:   w_id_next = S_MA;
      OP_R: begin
        if (!w_r_ok)          w_id_ok   = 1'b0;
        else if (Fun == FN_JR) w_id_next = S_JR;
        else                  w_id_next = S_EXR;
      end
      OP_BEQ, OP_BNE: w_id_next = S_BR;
      OP_J:           w_id_next = S_JMP;
      OP_JAL:         w_id_next = S_JAL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: w_id_next = S_EXI;
      OP_LUI:         w_id_next = S_LUI;
      default:        w_id_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pcwrite   = 1'b0;
    w_iord      = 1'b0;
    w_memread   = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_regdst    = 2'b00;
    w_datatoreg = 2'b00;
    w_alusrc_a  = 2'b00;
    w_alusrc_b  = 2'b00;
    w_pcsource  = 2'b00;
    w_alu       = ALU_AND;
    case (r_state)
      S_IF: begin
        w_memread  = 1'b1;
        w_alusrc_b = 2'b01;
        w_alu      = ALU_ADD;
        w_irwrite  = w_mio_ok;
        w_pcwrite  = w_mio_ok;
        w_next     = w_mio_ok ? S_ID : S_IF;
      end
      S_ID: begin
        // Branch target precomputed into ALUOut.
        w_alusrc_b = 2'b11;
        w_alu      = ALU_ADD;
        w_illegal  = ~w_id_ok;
        w_next     = w_id_next;
      end
      S_MA: begin
        w_alusrc_a = 2'b01;
        w_alusrc_b = 2'b10;
        w_alu      = ALU_ADD;
        w_next     = (OPcode == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_next    = w_mio_ok ? S_MWB : S_MRD;
      end
      S_MWB: begin
        w_regwrite  = 1'b1;
        w_datatoreg = 2'b01;
        w_next      = S_IF;
      end
      S_MWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_next     = w_mio_ok ? S_IF : S_MWR;
      end
      S_EXR: begin
        w_alusrc_a = (Fun == FN_SRL) ? 2'b10 : 2'b01;
        w_alu      = w_r_alu;
        w_next     = S_RWB;
      end
      S_RWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 2'b01;
        w_next     = S_IF;
      end
      S_BR: begin
        w_alusrc_a = 2'b01;
        w_alu      = ALU_SUB;
        w_pcsource = 2'b01;
        w_pcwrite  = (OPcode == OP_BNE) ? ~zero : zero;
        w_next     = S_IF;
      end
      S_JMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
        w_next     = S_IF;
      end
      S_EXI: begin
        w_alusrc_a = 2'b01;
        w_alusrc_b = 2'b10;
        w_alu      = w_i_alu;
        w_next     = S_IWB;
      end
      S_IWB: begin
        w_regwrite = 1'b1;
        w_next     = S_IF;
      end
      S_JAL: begin
        // PC already holds PC+4 from IF, which is the link value.
        w_regwrite  = 1'b1;
        w_regdst    = 2'b10;
        w_datatoreg = 2'b11;
        w_pcwrite   = 1'b1;
        w_pcsource  = 2'b10;
        w_next      = S_IF;
      end
      S_JR: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b11;
        w_next     = S_IF;
      end
      S_LUI: begin
        w_regwrite  = 1'b1;
        w_datatoreg = 2'b10;
        w_next      = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  // Outputs are forced low while reset is held so that a reset landing
  // mid-instruction cannot leak a write strobe.
  assign PCWrite     = rst_n & w_pcwrite;
  assign IorD        = rst_n & w_iord;
  assign MemRead     = rst_n & w_memread;
  assign MemWrite    = rst_n & w_memwrite;
  assign IRWrite     = rst_n & w_irwrite;
  assign RegWrite    = rst_n & w_regwrite;
  assign illegal     = rst_n & w_illegal;
  assign RegDst      = rst_n ? w_regdst    : 2'b00;
  assign DatatoReg   = rst_n ? w_datatoreg : 2'b00;
  assign ALUSrc_A    = rst_n ? w_alusrc_a  : 2'b00;
  assign ALUSrc_B    = rst_n ? w_alusrc_b  : 2'b00;
  assign PCSource    = rst_n ? w_pcsource  : 2'b00;
  assign ALU_Control = rst_n ? w_alu       : 3'b000;
  assign CPU_MIO     = MemRead | MemWrite;
  assign state       = rst_n ? r_state     : 4'd0;

endmodule
